// File: rtl/mac_seq_if.sv
// Command, operand-memory and MAC-side signals of the dot-product sequencer.
// The slave modport is the sequencer's view; master is the surrounding system.
interface mac_seq_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LEN_W  = 10
);
  logic              start;
  logic [LEN_W-1:0]  len;
  logic [ADDR_W-1:0] a_base;
  logic [ADDR_W-1:0] b_base;
  logic [15:0]       bias;
  logic              relu_en;
  logic              busy;
  logic              done;
  logic [15:0]       result;
  logic              rd_en;
  logic              rd_gnt;
  logic [ADDR_W-1:0] a_addr;
  logic [ADDR_W-1:0] b_addr;
  logic [15:0]       a_rdata;
  logic [15:0]       b_rdata;
  logic              mac_valid;
  logic [15:0]       mac_in1;
  logic [15:0]       mac_in2;
  logic [15:0]       mac_in3;
  logic [15:0]       mac_out;

  modport master (
    output start, len, a_base, b_base, bias, relu_en, rd_gnt, a_rdata, b_rdata, mac_out,
    input  busy, done, result, rd_en, a_addr, b_addr, mac_valid, mac_in1, mac_in2, mac_in3
  );

  modport slave (
    input  start, len, a_base, b_base, bias, relu_en, rd_gnt, a_rdata, b_rdata, mac_out,
    output busy, done, result, rd_en, a_addr, b_addr, mac_valid, mac_in1, mac_in2, mac_in3
  );
endinterface

// File: rtl/mac_seq.sv
// Dot-product sequencer: fetches len operand pairs, streams them into a Q8.8 MAC with
// bias preload and accumulator feedback, and returns the (optionally ReLU'd) result.
module mac_seq #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LEN_W  = 10
) (
  input logic     clk,
  input logic     rst,
  mac_seq_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StFin} state_e;

  state_e            state_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] a_base_q;
  logic [ADDR_W-1:0] b_base_q;
  logic [15:0]       bias_q;
  logic              relu_q;
  logic              first_q;
  logic              dv_q;
  logic              done_q;
  logic [15:0]       result_q;
  logic [15:0]       r;

  assign bus.busy      = (state_q != StIdle);
  assign bus.rd_en     = (state_q == StFetch);
  assign bus.a_addr    = a_base_q + ADDR_W'(cnt_q);
  assign bus.b_addr    = b_base_q + ADDR_W'(cnt_q);
  assign bus.mac_valid = dv_q;
  assign bus.mac_in1   = first_q ? bias_q : bus.mac_out;
  assign bus.mac_in2   = bus.a_rdata;
  assign bus.mac_in3   = bus.b_rdata;
  assign bus.done      = done_q;
  assign bus.result    = result_q;

  // An empty vector never touches the MAC, so the bias itself is the result.
  assign r = (len_q == '0) ? bias_q : bus.mac_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      len_q    <= '0;
      cnt_q    <= '0;
      a_base_q <= '0;
      b_base_q <= '0;
      bias_q   <= '0;
      relu_q   <= 1'b0;
      first_q  <= 1'b0;
      dv_q     <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      dv_q   <= bus.rd_en & bus.rd_gnt;
      done_q <= 1'b0;
      if (dv_q) begin
        first_q <= 1'b0;
      end
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            len_q    <= bus.len;
            a_base_q <= bus.a_base;
            b_base_q <= bus.b_base;
            bias_q   <= bus.bias;
            relu_q   <= bus.relu_en;
            cnt_q    <= '0;
            first_q  <= 1'b1;
            state_q  <= (bus.len == '0) ? StFin : StFetch;
          end
        end
        StFetch: begin
          if (bus.rd_gnt) begin
            cnt_q <= cnt_q + LEN_W'(1);
            if (cnt_q == len_q - LEN_W'(1)) begin
              state_q <= StDrain;
            end
          end
        end
        // Covers the data stage of the last granted read.
        StDrain: state_q <= StFin;
        StFin: begin
          result_q <= (relu_q & r[15]) ? 16'h0000 : r;
          done_q   <= 1'b1;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_seq.sv
// Self-checking bench for mac_seq: models the operand memories and the Q8.8 MAC, and
// checks results, latency and handshake behaviour against a vector-level reference.
module tb_mac_seq;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned LEN_W  = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mac_seq_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();
  mac_seq #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [15:0] mem_a [0:65535];
  logic [15:0] mem_b [0:65535];

  int n_tests = 0;
  int n_fail  = 0;

  // Per-operation observations collected by run_op.
  int          lat, stalls, rd_cycles, rd_first, mv_count, mv_first, mv_last;
  logic [15:0] res, in1_first;
  bit          busy_at_done;
  logic [15:0] addr_q[$];
  bit          gnt_q[$];
  logic [15:0] ga_q[$];
  logic [15:0] gb_q[$];

  function automatic logic [15:0] q88_mac(logic [15:0] acc, logic [15:0] a, logic [15:0] b);
    int p, s;
    p = int'($signed(a)) * int'($signed(b));
    s = int'($signed(acc)) + (p >>> 8);
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    return s[15:0];
  endfunction

  function automatic logic [15:0] ref_dot(int n, logic [15:0] ab, logic [15:0] bb,
                                          logic [15:0] bias, bit relu);
    logic [15:0] acc;
    acc = bias;
    for (int i = 0; i < n; i++) acc = q88_mac(acc, mem_a[ab + 16'(i)], mem_b[bb + 16'(i)]);
    if (relu && acc[15]) acc = 16'h0000;
    return acc;
  endfunction

  // Environment: registered MAC and single-cycle operand memories.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus.mac_out <= 16'h0000;
    else if (bus.mac_valid) bus.mac_out <= q88_mac(bus.mac_in1, bus.mac_in2, bus.mac_in3);
  end

  always_ff @(posedge clk) begin
    if (bus.rd_en && bus.rd_gnt) begin
      bus.a_rdata <= mem_a[bus.a_addr];
      bus.b_rdata <= mem_b[bus.b_addr];
    end
  end

  // mode 0: grant always, 1: grant on even cycles, 2: random grant.
  task automatic run_op(input int n, input logic [15:0] ab, input logic [15:0] bb,
                        input logic [15:0] bias, input bit relu, input int mode,
                        input int restart_at);
    int c;
    bit g, fin;
    addr_q.delete(); gnt_q.delete(); ga_q.delete(); gb_q.delete();
    stalls = 0; rd_cycles = 0; rd_first = -1; mv_count = 0; mv_first = -1; mv_last = -1;
    lat = -1; busy_at_done = 1'b1; in1_first = 16'hxxxx; res = 16'hxxxx;
    bus.start = 1'b1; bus.len = LEN_W'(n); bus.a_base = ab; bus.b_base = bb;
    bus.bias = bias; bus.relu_en = relu; bus.rd_gnt = (mode == 0);
    c = 0; fin = 1'b0;
    while (!fin) begin
      @(negedge clk);
      c++;
      bus.start = (c == restart_at);
      if (bus.start) begin
        bus.len = 10'd7; bus.a_base = 16'h1234; bus.bias = 16'h7000;
      end
      if (bus.done) begin
        res = bus.result; lat = c; busy_at_done = bus.busy; fin = 1'b1;
      end else if (c > 3000) begin
        $display("FAIL run_timeout: no done after %0d cycles, wanted one", c);
        fin = 1'b1;
      end else begin
        case (mode)
          0: g = 1'b1;
          1: g = (c % 2 == 0);
          default: g = ($urandom_range(0, 2) != 0);
        endcase
        bus.rd_gnt = g;
        if (bus.rd_en) begin
          rd_cycles++;
          if (rd_first < 0) rd_first = c;
          addr_q.push_back(bus.a_addr);
          gnt_q.push_back(g);
          if (!g) stalls++;
          else begin ga_q.push_back(bus.a_addr); gb_q.push_back(bus.b_addr); end
        end
        if (bus.mac_valid) begin
          mv_count++;
          if (mv_first < 0) begin mv_first = c; in1_first = bus.mac_in1; end
          mv_last = c;
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++;
    if ({bus.busy, bus.done, bus.rd_en, bus.mac_valid} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy/done/rd_en/mac_valid=%b want 0000",
               {bus.busy, bus.done, bus.rd_en, bus.mac_valid});
    end
    n_tests++;
    if (bus.result !== 16'h0000) begin
      n_fail++; $display("FAIL reset_result: got %h want 0000", bus.result);
    end
    n_tests++;
    if ({bus.a_addr, bus.b_addr} !== 32'h0) begin
      n_fail++; $display("FAIL reset_addr: got %h/%h want 0/0", bus.a_addr, bus.b_addr);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    for (int i = 0; i < 3; i++) begin
      mem_a[16'h0010 + 16'(i)] = 16'h0100;
      mem_b[16'h0040 + 16'(i)] = 16'h0200;
    end
    run_op(3, 16'h0010, 16'h0040, 16'h0080, 1'b0, 0, -1);
    n_tests++;
    if (res !== 16'h0680) begin n_fail++; $display("FAIL basic_result: got %h want 0680", res); end
    n_tests++;
    if (lat != 6) begin n_fail++; $display("FAIL basic_latency: got %0d want 6", lat); end
    n_tests++;
    if (mv_first != 2 || mv_last != 4 || mv_count != 3) begin
      n_fail++;
      $display("FAIL basic_mac_valid: first %0d last %0d count %0d want 2 4 3",
               mv_first, mv_last, mv_count);
    end
    n_tests++;
    if (in1_first !== 16'h0080) begin
      n_fail++; $display("FAIL basic_bias_preload: got %h want 0080", in1_first);
    end
    n_tests++;
    if (rd_first != 1 || rd_cycles != 3) begin
      n_fail++; $display("FAIL basic_rd_en: first %0d count %0d want 1 3", rd_first, rd_cycles);
    end
    n_tests++;
    if (busy_at_done) begin n_fail++; $display("FAIL basic_busy_at_done: got 1 want 0"); end
  endtask

  task automatic test_stalls();
    int grants;
    bit bad;
    run_op(3, 16'h0010, 16'h0040, 16'h0080, 1'b0, 1, -1);
    n_tests++;
    if (res !== 16'h0680) begin n_fail++; $display("FAIL stall_result: got %h want 0680", res); end
    n_tests++;
    if (stalls != 3 || lat != 9) begin
      n_fail++; $display("FAIL stall_latency: got %0d (stalls %0d) want 9", lat, stalls);
    end
    grants = 0; bad = 1'b0;
    foreach (addr_q[k]) begin
      if (addr_q[k] !== 16'h0010 + 16'(grants)) bad = 1'b1;
      if (gnt_q[k]) grants++;
    end
    n_tests++;
    if (bad || grants != 3) begin
      n_fail++; $display("FAIL stall_addr_hold: bad=%0d grants %0d want 0 3", bad, grants);
    end
  endtask

  task automatic test_relu_sat();
    for (int i = 0; i < 2; i++) begin
      mem_a[16'h0200 + 16'(i)] = 16'h7F00;
      mem_b[16'h0300 + 16'(i)] = 16'h8000;
    end
    run_op(2, 16'h0200, 16'h0300, 16'h0000, 1'b0, 0, -1);
    n_tests++;
    if (res !== 16'h8000) begin n_fail++; $display("FAIL sat_result: got %h want 8000", res); end
    run_op(2, 16'h0200, 16'h0300, 16'h0000, 1'b1, 0, -1);
    n_tests++;
    if (res !== 16'h0000) begin n_fail++; $display("FAIL relu_result: got %h want 0000", res); end
  endtask

  task automatic test_zero_len();
    run_op(0, 16'h0000, 16'h0000, 16'hFF00, 1'b0, 0, -1);
    n_tests++;
    if (res !== 16'hFF00) begin n_fail++; $display("FAIL zero_result: got %h want FF00", res); end
    n_tests++;
    if (lat != 2) begin n_fail++; $display("FAIL zero_latency: got %0d want 2", lat); end
    n_tests++;
    if (rd_cycles != 0 || mv_count != 0) begin
      n_fail++; $display("FAIL zero_no_access: rd %0d mv %0d want 0 0", rd_cycles, mv_count);
    end
  endtask

  task automatic test_busy_wrap();
    logic [15:0] exp;
    int busy_cnt;
    mem_a[16'hFFFF] = 16'h0180; mem_a[16'h0000] = 16'hFE40;
    mem_b[16'h0100] = 16'h0230; mem_b[16'h0101] = 16'h0310;
    exp = ref_dot(2, 16'hFFFF, 16'h0100, 16'h0020, 1'b0);
    run_op(2, 16'hFFFF, 16'h0100, 16'h0020, 1'b0, 0, 2);
    n_tests++;
    if (res !== exp) begin n_fail++; $display("FAIL wrap_result: got %h want %h", res, exp); end
    n_tests++;
    if (lat != 5) begin n_fail++; $display("FAIL busy_start_latency: got %0d want 5", lat); end
    n_tests++;
    if (ga_q.size() != 2 || ga_q[0] !== 16'hFFFF || ga_q[1] !== 16'h0000) begin
      n_fail++; $display("FAIL wrap_addr: got %p want FFFF,0000", ga_q);
    end
    busy_cnt = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (bus.busy) busy_cnt++; end
    n_tests++;
    if (busy_cnt != 0) begin
      n_fail++; $display("FAIL busy_start_ignored: busy %0d cycles after done want 0", busy_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] exp;
    int done_cnt;
    for (int i = 0; i < 5; i++) begin
      mem_a[16'h2000 + 16'(i)] = 16'($urandom());
      mem_b[16'h3000 + 16'(i)] = 16'($urandom());
    end
    bus.start = 1'b1; bus.len = 10'd5; bus.a_base = 16'h2000; bus.b_base = 16'h3000;
    bus.bias = 16'h0100; bus.relu_en = 1'b0; bus.rd_gnt = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++;
    if ({bus.busy, bus.done, bus.rd_en, bus.mac_valid} !== 4'b0000 || bus.result !== 16'h0
        || bus.a_addr !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: ctrl %b result %h a_addr %h want 0000 0000 0000",
               {bus.busy, bus.done, bus.rd_en, bus.mac_valid}, bus.result, bus.a_addr);
    end
    done_cnt = 0;
    for (int i = 0; i < 3; i++) begin @(negedge clk); if (bus.done) done_cnt++; end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (bus.done) done_cnt++; end
    n_tests++;
    if (done_cnt != 0) begin n_fail++; $display("FAIL reset_mid_no_done: got %0d want 0", done_cnt); end
    exp = ref_dot(5, 16'h2000, 16'h3000, 16'h0100, 1'b0);
    run_op(5, 16'h2000, 16'h3000, 16'h0100, 1'b0, 2, -1);
    n_tests++;
    if (res !== exp || lat != 8 + stalls) begin
      n_fail++;
      $display("FAIL reset_mid_rerun: result %h lat %0d want %h %0d", res, lat, exp, 8 + stalls);
    end
  endtask

  // Operations issued back to back: each start lands in the previous done cycle.
  task automatic test_random();
    int n, exp_lat;
    logic [15:0] ab, bb, bias, exp;
    bit relu, bad;
    for (int it = 0; it < 25; it++) begin
      n = $urandom_range(0, 8);
      ab = 16'($urandom()); bb = 16'($urandom()); bias = 16'($urandom());
      relu = 1'($urandom());
      for (int i = 0; i < n; i++) begin
        mem_a[ab + 16'(i)] = 16'($urandom());
        mem_b[bb + 16'(i)] = 16'($urandom());
      end
      exp = ref_dot(n, ab, bb, bias, relu);
      run_op(n, ab, bb, bias, relu, 2, -1);
      exp_lat = (n == 0) ? 2 : n + 3 + stalls;
      n_tests++;
      if (res !== exp) begin
        n_fail++; $display("FAIL rand_result[%0d]: got %h want %h (len %0d)", it, res, exp, n);
      end
      n_tests++;
      if (lat != exp_lat) begin
        n_fail++; $display("FAIL rand_latency[%0d]: got %0d want %0d", it, lat, exp_lat);
      end
      bad = (ga_q.size() != n) || (mv_count != n);
      foreach (ga_q[k]) if (ga_q[k] !== ab + 16'(k) || gb_q[k] !== bb + 16'(k)) bad = 1'b1;
      n_tests++;
      if (bad) begin
        n_fail++;
        $display("FAIL rand_addr_seq[%0d]: grants %0d mac_valid %0d want %0d with base+k addrs",
                 it, ga_q.size(), mv_count, n);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.len = '0; bus.a_base = '0; bus.b_base = '0;
    bus.bias = '0; bus.relu_en = 1'b0; bus.rd_gnt = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_basic();
    test_stalls();
    test_relu_sat();
    test_zero_len();
    test_busy_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
